// File: rtl/hb_sched_pkg.sv
// Shared types and defaults for the heartbeat/blink scheduler.
// Optional build macro: HB_SCHED_IDLE_HEARTBEAT_EN (see hb_sched.sv).
package hb_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int DEF_NREQ = 4;
   localparam int DEF_PW   = 8;
   localparam int DEF_DIVW = 8;

   // Index width that stays legal for a single-entry range.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hb_rr_arbiter.sv
// Combinational round-robin pick: the lowest requester at or above i_ptr
// wins, otherwise the lowest requester overall (wrap-around).
module hb_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
)(
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant
);

   logic [NREQ-1:0] w_hi;
   logic [NREQ-1:0] w_pick;

   always_comb begin
      w_hi = '0;
      for (int j = 0; j < NREQ; j++) begin
         w_hi[j] = i_req[j] && (j >= int'(i_ptr));
      end
   end

   assign w_pick  = (|w_hi) ? w_hi : i_req;
   // Two's-complement trick isolates the lowest set bit.
   assign o_grant = w_pick & (~w_pick + NREQ'(1));

endmodule

// File: rtl/hb_sched.sv
// Shared-LED blink scheduler: round-robin grants one requester, plays its
// latched pattern one bit per prescaler tick, then a one-tick dark GAP.
// Build macro HB_SCHED_IDLE_HEARTBEAT_EN enables an idle heartbeat pulse.
module hb_sched
   import hb_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = DEF_PW,
   parameter int DIVW = DEF_DIVW
)(
   input  logic               clk,
   input  logic               nreset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*PW-1:0] pattern,
   input  logic [DIVW-1:0]    div,
   output logic [NREQ-1:0]    grant,
   output logic               busy,
   output logic               done,
   output logic               out,
   output state_t             o_dbg_state
);

   localparam int IW = idx_w(NREQ);
   localparam int BW = idx_w(PW);

   state_t          r_state;
   logic [NREQ-1:0] r_grant;
   logic [IW-1:0]   r_ptr;
   logic [PW-1:0]   r_pat;
   logic [BW-1:0]   r_idx;
   logic [DIVW-1:0] r_presc;
   logic            r_out;

   logic [NREQ-1:0] w_arb_gnt;
   logic [PW-1:0]   w_pat_sel;
   logic [IW-1:0]   w_next_ptr;
   logic [BW-1:0]   w_idx_nxt;
   logic [DIVW-1:0] w_presc_nxt;
   logic            w_tick;

   hb_rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_arb_gnt)
   );

   // ">=" rather than "==" so a lowered div wraps an overshooting count.
   assign w_tick      = (r_presc >= div);
   assign w_presc_nxt = w_tick ? '0 : r_presc + DIVW'(1);
   assign w_idx_nxt   = r_idx + BW'(1);

   always_comb begin
      w_pat_sel  = '0;
      w_next_ptr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_arb_gnt[i]) begin
            w_pat_sel  = pattern[i*PW +: PW];
            w_next_ptr = (i == NREQ-1) ? '0 : IW'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
         r_pat   <= '0;
         r_idx   <= '0;
         r_presc <= '0;
         r_out   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_state <= PLAY;
                  r_grant <= w_arb_gnt;
                  r_ptr   <= w_next_ptr;
                  r_pat   <= w_pat_sel;
                  r_idx   <= '0;
                  r_presc <= '0;
                  r_out   <= w_pat_sel[0];
               end else begin
`ifdef HB_SCHED_IDLE_HEARTBEAT_EN
                  r_presc <= w_presc_nxt;
                  r_out   <= w_tick;
`else
                  r_presc <= '0;
                  r_out   <= 1'b0;
`endif
               end
            end
            PLAY: begin
               r_presc <= w_presc_nxt;
               if (w_tick) begin
                  if (r_idx == BW'(PW-1)) begin
                     r_state <= GAP;
                     r_out   <= 1'b0;
                  end else begin
                     r_idx <= w_idx_nxt;
                     r_out <= r_pat[w_idx_nxt];
                  end
               end
            end
            GAP: begin
               r_presc <= w_presc_nxt;
               if (w_tick) begin
                  r_state <= IDLE;
                  r_grant <= '0;
                  r_idx   <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= '0;
               r_out   <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == GAP) && w_tick;
   assign out         = r_out;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hb_sched.sv
// Self-checking bench for hb_sched: directed vector table, hand-written
// reset/div/heartbeat sequences and randomized transactions vs. a model.
module tb_hb_sched;
   import hb_sched_pkg::*;

   localparam int NREQ = 4;
   localparam int PW   = 8;
   localparam int DIVW = 8;
   localparam int PATW = NREQ*PW;

   logic            clk;
   logic            nreset;
   logic [NREQ-1:0] req;
   logic [PATW-1:0] pattern;
   logic [DIVW-1:0] div;
   logic [NREQ-1:0] grant;
   logic            busy;
   logic            done;
   logic            out;
   state_t          dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   int m_last = NREQ - 1;   // model: last granted index (so first search starts at 0)

   hb_sched #(
      .NREQ (NREQ),
      .PW   (PW),
      .DIVW (DIVW)
   ) dut (
      .clk         (clk),
      .nreset      (nreset),
      .req         (req),
      .pattern     (pattern),
      .div         (div),
      .grant       (grant),
      .busy        (busy),
      .done        (done),
      .out         (out),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input integer act, input integer exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model arbitration: first requester scanning upward from last+1, wrapping.
   function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
      int s;
      s = (last + 1) % NREQ;
      for (int k = 0; k < NREQ; k++) begin
         if (r[(s + k) % NREQ]) return (s + k) % NREQ;
      end
      return -1;
   endfunction

   // One IDLE cycle with req=r driven, then (if r!=0) the full granted
   // sequence. mode 0: hold req; 1: drop winner's req at bit 3;
   // 2: scramble req and pattern every cycle.
   task automatic run_txn(input logic [NREQ-1:0] r, input logic [PATW-1:0] pat,
                          input int d, input int mode, input int exp_w,
                          input int exp_len);
      logic [PATW-1:0] sh;
      int pv, len, done_at, bit_i, exp_out;
      @(posedge clk); #1;
      req = r; pattern = pat; div = DIVW'(d);
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_grant", 32'(grant), 0);
      check("idle_done", 32'(done), 0);
`ifndef HB_SCHED_IDLE_HEARTBEAT_EN
      check("idle_out", 32'(out), 0);
`endif
      if (r == '0) return;
      sh      = pat >> (exp_w * PW);
      pv      = int'(sh[PW-1:0]);
      len     = (PW + 1) * (d + 1);
      done_at = 0;
      for (int c = 1; c <= len; c++) begin
         @(posedge clk); #1;
         if (mode == 1 && c == 3 * (d + 1) + 1) req = r & ~(NREQ'(1) << exp_w);
         if (mode == 2) begin
            req     = NREQ'($urandom);
            pattern = PATW'($urandom);
         end
         @(negedge clk);
         bit_i   = (c - 1) / (d + 1);
         exp_out = (bit_i < PW) ? ((pv >> bit_i) & 1) : 0;
         check("out", 32'(out), exp_out);
         check("grant", 32'(grant), 1 << exp_w);
         check("busy", 32'(busy), 1);
         check("done", 32'(done), (c == len) ? 1 : 0);
         if (done && done_at == 0) done_at = c;
      end
      check("done_latency", done_at, exp_len);
      m_last = exp_w;
   endtask

   task automatic wait_idle(input int budget);
      int seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1;
            break;
         end
      end
      if (seen == 0) check("wait_idle_timeout", 1, 0);
   endtask

   typedef struct {
      logic [NREQ-1:0] r;
      logic [PATW-1:0] pat;
      int              d;
      int              mode;
      int              exp_w;
      int              exp_len;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int done_at, hb_cnt, hb_last;
      logic [NREQ-1:0] rr;
      int dd;

      tbl[0]  = '{4'b0001, 32'h5C5C_5CA3, 0, 0,  0,  9};
      tbl[1]  = '{4'b0001, 32'h5C5C_5CA3, 3, 0,  0, 36};
      tbl[2]  = '{4'b1111, 32'h1234_56A3, 0, 0,  1,  9};
      tbl[3]  = '{4'b1111, 32'h1234_56A3, 0, 0,  2,  9};
      tbl[4]  = '{4'b1111, 32'h1234_56A3, 0, 0,  3,  9};
      tbl[5]  = '{4'b1111, 32'h1234_56A3, 0, 0,  0,  9};
      tbl[6]  = '{4'b0001, 32'hFFFF_FF6B, 2, 1,  0, 27};
      tbl[7]  = '{4'b1010, 32'h9E00_C700, 1, 0,  1, 18};
      tbl[8]  = '{4'b0000, 32'h0000_0000, 0, 0, -1,  0};
      tbl[9]  = '{4'b0001, 32'h0000_00A3, 0, 0,  0,  9};
      tbl[10] = '{4'b1000, 32'hB500_0000, 1, 0,  3, 18};

      nreset = 1'b0; req = '0; pattern = '0; div = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_done", 32'(done), 0);
      check("rst_out", 32'(out), 0);
      nreset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_txn(tbl[i].r, tbl[i].pat, tbl[i].d, tbl[i].mode, tbl[i].exp_w, tbl[i].exp_len);
      end

      // Asynchronous reset in the middle of PLAY, then restart from index 0.
      @(posedge clk); #1;
      req = 4'b0100; pattern = 32'h00FF_0000; div = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_rst_out", 32'(out), 1);
      check("pre_rst_grant", 32'(grant), 4);
      #2 nreset = 1'b0;
      #1;
      check("async_rst_out", 32'(out), 0);
      check("async_rst_grant", 32'(grant), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_done", 32'(done), 0);
      req = 4'b1111;
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 1);
      check("post_rst_grant", 32'(grant), 1);
      m_last = 0;
      wait_idle(200);

      // Lower div mid-bit: overshooting prescaler wraps immediately.
      @(posedge clk); #1;
      req = 4'b0001; pattern = 32'h0000_0001; div = 8'd7;
      done_at = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 1) req = '0;
         if (c == 3) div = 8'd1;
         @(negedge clk);
         if (c == 3) check("div_bit0_out", 32'(out), 1);
         if (c == 4) check("div_bit1_out", 32'(out), 0);
         if (done && done_at == 0) done_at = c;
      end
      check("div_live_done", done_at, 19);
      m_last = 0;

      // Idle behaviour with div=7 over a 64-cycle window.
      req = '0; div = 8'd7;
      hb_cnt = 0; hb_last = -1;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (out) begin
`ifdef HB_SCHED_IDLE_HEARTBEAT_EN
            if (hb_last >= 0) check("hb_spacing", c - hb_last, 8);
`endif
            hb_cnt++;
            hb_last = c;
         end
      end
`ifdef HB_SCHED_IDLE_HEARTBEAT_EN
      check("hb_pulses", hb_cnt, 8);
`else
      check("idle_out_quiet", hb_cnt, 0);
`endif

      // Randomized transactions against the model.
      for (int n = 0; n < 40; n++) begin
         rr = NREQ'($urandom_range(0, 15));
         dd = $urandom_range(0, 3);
         if (rr == '0)
            run_txn(rr, PATW'($urandom), dd, 2, -1, 0);
         else
            run_txn(rr, PATW'($urandom), dd, 2, rr_pick(rr, m_last), (PW + 1) * (dd + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
